// File: rtl/df_pkg.sv
// rtl/df_pkg.sv - shared constants and operand word type for the df_reg pipeline register
package df_pkg;

  localparam int DF_DEFAULT_WIDTH = 4;
  localparam int DF_DEFAULT_RESET = 0;

  typedef logic [DF_DEFAULT_WIDTH-1:0] df_word_t;

endpackage

// File: rtl/df_bit.sv
// rtl/df_bit.sv - single-bit flop with asynchronous active-high reset, reset value and load enable
module df_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic d,
  output logic q,
  input  logic r,
  input  logic clk,
  input  logic ce
);

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q <= RST_VAL;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/df_reg.sv
// rtl/df_reg.sv - WIDTH-bit pipeline register, one df_bit per bit
// Optional clock enable port ce is added when DF_REG_CE_EN is defined.
module df_reg
  import df_pkg::*;
#(
  parameter int         WIDTH     = DF_DEFAULT_WIDTH,
  parameter logic [63:0] RESET_VAL = 64'(DF_DEFAULT_RESET)
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             r,
  input  logic             clk
`ifdef DF_REG_CE_EN
  ,
  input  logic             ce
`endif
);

  logic load;

`ifdef DF_REG_CE_EN
  assign load = ce;
`else
  assign load = 1'b1;
`endif

  // Only the low WIDTH bits of RESET_VAL reach the flops.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    df_bit #(
      .RST_VAL(RESET_VAL[i])
    ) u_bit (
      .d  (d[i]),
      .q  (q[i]),
      .r  (r),
      .clk(clk),
      .ce (load)
    );
  end

endmodule

// File: tb/tb_df_reg.sv
// tb/tb_df_reg.sv - directed self-checking bench for df_reg (default and 8-bit builds)
`timescale 1ns/100ps
module tb_df_reg;

  logic       clk = 1'b0;
  logic       r4  = 1'b0;
  logic       r8  = 1'b0;
  logic [3:0] d4  = 4'hF;
  logic [7:0] d8  = 8'hFF;
  logic [3:0] q4;
  logic [7:0] q8;
`ifdef DF_REG_CE_EN
  logic       ce  = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  df_reg dut4 (
    .d  (d4),
    .q  (q4),
    .r  (r4),
    .clk(clk)
`ifdef DF_REG_CE_EN
    ,
    .ce (ce)
`endif
  );

  df_reg #(
    .WIDTH    (8),
    .RESET_VAL(64'hA5)
  ) dut8 (
    .d  (d8),
    .q  (q8),
    .r  (r8),
    .clk(clk)
`ifdef DF_REG_CE_EN
    ,
    .ce (ce)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset assertion before any clock edge
    #1;
    r4 = 1'b1;
    r8 = 1'b1;
    #0.1;
    check("reset_async_4", q4, 4'h0);
    check("reset_async_8", q8, 8'hA5);

    // Reset held over three edges with d all ones
    for (int i = 0; i < 3; i++) begin
      edge_then_sample();
      check("reset_hold_4", q4, 4'h0);
      check("reset_hold_8", q8, 8'hA5);
    end

    // Release mid-cycle: q keeps the reset value until the next edge
    @(negedge clk);
    r4 = 1'b0;
    r8 = 1'b0;
    d4 = 4'h3;
    d8 = 8'h3C;
    #1;
    check("release_hold_4", q4, 4'h0);
    check("release_hold_8", q8, 8'hA5);

    // Pipeline: each value appears one edge later
    edge_then_sample();
    check("pipe_3", q4, 4'h3);
    check("w8_3c", q8, 8'h3C);
    @(negedge clk);
    d4 = 4'hA;
    d8 = 8'hC3;
    edge_then_sample();
    check("pipe_a", q4, 4'hA);
    check("w8_c3", q8, 8'hC3);
    @(negedge clk);
    d4 = 4'h7;
    edge_then_sample();
    check("pipe_7", q4, 4'h7);

    // Glitches on d between edges do not reach q
    @(negedge clk);
    d4 = 4'h2;
    #1 d4 = 4'hE;
    #1 d4 = 4'hC;
    #0.1;
    check("glitch_hold", q4, 4'h7);
    edge_then_sample();
    check("pipe_c", q4, 4'hC);

    // Reset mid-operation clears q in the same time step
    @(negedge clk);
    #2 r4 = 1'b1;
    r8 = 1'b1;
    #0.1;
    check("mid_reset_4", q4, 4'h0);
    check("mid_reset_8", q8, 8'hA5);
    d4 = 4'h5;
    #1 r4 = 1'b0;
    r8 = 1'b0;
    #0.1;
    check("mid_release", q4, 4'h0);
    edge_then_sample();
    check("after_reset_5", q4, 4'h5);
    check("w8_after_reset", q8, 8'hC3);

    // Reset rising at the same instant as a clock edge wins
    @(negedge clk);
    d4 = 4'h9;
    @(posedge clk);
    r4 = 1'b1;
    #1;
    check("simul_reset", q4, 4'h0);
    @(negedge clk);
    r4 = 1'b0;
    d4 = 4'hF;
    edge_then_sample();
    check("all_ones", q4, 4'hF);
    @(negedge clk);
    d4 = 4'h0;
    edge_then_sample();
    check("all_zeros", q4, 4'h0);

`ifdef DF_REG_CE_EN
    // Clock enable low holds q; raising it loads on the next edge
    @(negedge clk);
    d4 = 4'h1;
    edge_then_sample();
    check("ce_setup_1", q4, 4'h1);
    @(negedge clk);
    ce = 1'b0;
    d4 = 4'h6;
    for (int i = 0; i < 2; i++) begin
      edge_then_sample();
      check("ce_low_hold", q4, 4'h1);
    end
    @(negedge clk);
    ce = 1'b1;
    edge_then_sample();
    check("ce_high_load", q4, 4'h6);
    @(negedge clk);
    ce = 1'b0;
    r4 = 1'b1;
    #0.1;
    check("ce_reset_override", q4, 4'h0);
    r4 = 1'b0;
    ce = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
